axil_cfg_sequencer: RTL and testbench

AXI4-Lite master that programs the subsystem's register slave and then verifies it. On a start pulse it writes NUM_REGS consecutive 32-bit registers from a flat configuration vector. It then reads every register back, compares each value against what was written, and reports pass/fail and an error count. It sits between the subsystem control logic and the S00_AXI register port and replaces the bench-driven write/read sequence in hardware.

---
 rtl/axil_cfg_sequencer.sv | 287 ++++++++++++++++++++++++++++
 tb/tb_axil_cfg_sequencer.sv | 355 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axil_cfg_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : axil_cfg_sequencer
// Description : AXI4-Lite master that writes NUM_REGS consecutive registers
//               from a configuration vector, reads them back, and reports
//               pass/fail with a saturating error count.
// Revision    : 1.0 - initial release
// ============================================================================
module axil_cfg_sequencer #(
  parameter int unsigned       NUM_REGS  = 4,
  parameter int unsigned       ADDR_W    = 32,
  parameter int unsigned       DATA_W    = 32,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
  input  logic                                 ACLK,
  input  logic                                 ARESET,
  input  logic                                 start,
  input  logic [NUM_REGS*DATA_W-1:0]           cfg_data,
  output logic                                 busy,
  output logic                                 done,
  output logic                                 pass,
  output logic [$clog2(2*NUM_REGS+1)-1:0]      err_cnt,
  output logic [ADDR_W-1:0]                    m_axi_awaddr,
  output logic [2:0]                           m_axi_awprot,
  output logic                                 m_axi_awvalid,
  input  logic                                 m_axi_awready,
  output logic [DATA_W-1:0]                    m_axi_wdata,
  output logic [DATA_W/8-1:0]                  m_axi_wstrb,
  output logic                                 m_axi_wvalid,
  input  logic                                 m_axi_wready,
  input  logic [1:0]                           m_axi_bresp,
  input  logic                                 m_axi_bvalid,
  output logic                                 m_axi_bready,
  output logic [ADDR_W-1:0]                    m_axi_araddr,
  output logic [2:0]                           m_axi_arprot,
  output logic                                 m_axi_arvalid,
  input  logic                                 m_axi_arready,
  input  logic [DATA_W-1:0]                    m_axi_rdata,
  input  logic [1:0]                           m_axi_rresp,
  input  logic                                 m_axi_rvalid,
  output logic                                 m_axi_rready
);

  localparam int unsigned       IDX_W    = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam int unsigned       ERR_W    = $clog2(2*NUM_REGS+1);
  localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(NUM_REGS-1);
  localparam logic [ERR_W-1:0]  ERR_MAX  = '1;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WR_REQ  = 3'd1,
    WR_RESP = 3'd2,
    RD_REQ  = 3'd3,
    RD_RESP = 3'd4,
    FINISH  = 3'd5
  } state_t;

  // Byte address of register i (32-bit registers, stride 4).
  function automatic logic [ADDR_W-1:0] reg_addr(input logic [IDX_W-1:0] i);
    return BASE_ADDR + (ADDR_W'(i) << 2);
  endfunction

  // Word i of a flat configuration vector.
  function automatic logic [DATA_W-1:0] reg_word(
    input logic [NUM_REGS*DATA_W-1:0] v,
    input logic [IDX_W-1:0]           i
  );
    return v[i*DATA_W +: DATA_W];
  endfunction

  // Error counter increment that sticks at the top value.
  function automatic logic [ERR_W-1:0] sat_inc(input logic [ERR_W-1:0] c);
    return (c == ERR_MAX) ? c : c + ERR_W'(1);
  endfunction

  state_t                     state_q,   state_d;
  logic [IDX_W-1:0]           idx_q,     idx_d;
  logic [NUM_REGS*DATA_W-1:0] shadow_q,  shadow_d;
  logic [ERR_W-1:0]           err_cnt_q, err_cnt_d;
  logic                       pass_q,    pass_d;
  logic                       done_q,    done_d;
  logic                       busy_q,    busy_d;
  logic                       awvalid_q, awvalid_d;
  logic                       wvalid_q,  wvalid_d;
  logic                       aw_done_q, aw_done_d;
  logic                       w_done_q,  w_done_d;
  logic [ADDR_W-1:0]          awaddr_q,  awaddr_d;
  logic [DATA_W-1:0]          wdata_q,   wdata_d;
  logic                       arvalid_q, arvalid_d;
  logic [ADDR_W-1:0]          araddr_q,  araddr_d;
  logic                       bready_q,  bready_d;
  logic                       rready_q,  rready_d;

  logic                       aw_hs;
  logic                       w_hs;
  logic                       b_hs;
  logic                       ar_hs;
  logic                       r_hs;
  logic                       rd_bad;
  logic [IDX_W-1:0]           idx_nxt;

  assign aw_hs   = awvalid_q & m_axi_awready;
  assign w_hs    = wvalid_q  & m_axi_wready;
  assign b_hs    = bready_q  & m_axi_bvalid;
  assign ar_hs   = arvalid_q & m_axi_arready;
  assign r_hs    = rready_q  & m_axi_rvalid;
  assign rd_bad  = (m_axi_rresp != 2'b00) || (m_axi_rdata != reg_word(shadow_q, idx_q));
  assign idx_nxt = idx_q + IDX_W'(1);

  // Next-state and registered-output computation; every output is a flop so
  // AXI payloads stay stable while their valid waits for ready.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    shadow_d  = shadow_q;
    err_cnt_d = err_cnt_q;
    pass_d    = pass_q;
    done_d    = 1'b0;
    busy_d    = busy_q;
    awvalid_d = awvalid_q;
    wvalid_d  = wvalid_q;
    aw_done_d = aw_done_q;
    w_done_d  = w_done_q;
    awaddr_d  = awaddr_q;
    wdata_d   = wdata_q;
    arvalid_d = arvalid_q;
    araddr_d  = araddr_q;
    bready_d  = bready_q;
    rready_d  = rready_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          shadow_d  = cfg_data;
          err_cnt_d = '0;
          pass_d    = 1'b0;
          idx_d     = '0;
          busy_d    = 1'b1;
          awvalid_d = 1'b1;
          wvalid_d  = 1'b1;
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
          awaddr_d  = reg_addr('0);
          wdata_d   = reg_word(cfg_data, '0);
          state_d   = WR_REQ;
        end
      end

      WR_REQ: begin
        // AW and W complete independently; remember which one has finished.
        if (aw_hs) begin
          awvalid_d = 1'b0;
          aw_done_d = 1'b1;
        end
        if (w_hs) begin
          wvalid_d = 1'b0;
          w_done_d = 1'b1;
        end
        if ((aw_done_q || aw_hs) && (w_done_q || w_hs)) begin
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
          bready_d  = 1'b1;
          state_d   = WR_RESP;
        end
      end

      WR_RESP: begin
        if (b_hs) begin
          bready_d = 1'b0;
          if (m_axi_bresp != 2'b00) begin
            err_cnt_d = sat_inc(err_cnt_q);
          end
          if (idx_q == LAST_IDX) begin
            idx_d     = '0;
            arvalid_d = 1'b1;
            araddr_d  = reg_addr('0);
            state_d   = RD_REQ;
          end else begin
            idx_d     = idx_nxt;
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
            awaddr_d  = reg_addr(idx_nxt);
            wdata_d   = reg_word(shadow_q, idx_nxt);
            state_d   = WR_REQ;
          end
        end
      end

      RD_REQ: begin
        if (ar_hs) begin
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
          state_d   = RD_RESP;
        end
      end

      RD_RESP: begin
        if (r_hs) begin
          rready_d = 1'b0;
          // A bad response and a data mismatch on the same beat count once.
          if (rd_bad) begin
            err_cnt_d = sat_inc(err_cnt_q);
          end
          if (idx_q == LAST_IDX) begin
            idx_d   = '0;
            done_d  = 1'b1;
            busy_d  = 1'b0;
            pass_d  = (err_cnt_d == '0);
            state_d = FINISH;
          end else begin
            idx_d     = idx_nxt;
            arvalid_d = 1'b1;
            araddr_d  = reg_addr(idx_nxt);
            state_d   = RD_REQ;
          end
        end
      end

      FINISH: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      shadow_q  <= '0;
      err_cnt_q <= '0;
      pass_q    <= 1'b0;
      done_q    <= 1'b0;
      busy_q    <= 1'b0;
      awvalid_q <= 1'b0;
      wvalid_q  <= 1'b0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
      awaddr_q  <= '0;
      wdata_q   <= '0;
      arvalid_q <= 1'b0;
      araddr_q  <= '0;
      bready_q  <= 1'b0;
      rready_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      shadow_q  <= shadow_d;
      err_cnt_q <= err_cnt_d;
      pass_q    <= pass_d;
      done_q    <= done_d;
      busy_q    <= busy_d;
      awvalid_q <= awvalid_d;
      wvalid_q  <= wvalid_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
      awaddr_q  <= awaddr_d;
      wdata_q   <= wdata_d;
      arvalid_q <= arvalid_d;
      araddr_q  <= araddr_d;
      bready_q  <= bready_d;
      rready_q  <= rready_d;
    end
  end

  assign busy          = busy_q;
  assign done          = done_q;
  assign pass          = pass_q;
  assign err_cnt       = err_cnt_q;
  assign m_axi_awaddr  = awaddr_q;
  assign m_axi_awprot  = 3'b000;
  assign m_axi_awvalid = awvalid_q;
  assign m_axi_wdata   = wdata_q;
  assign m_axi_wstrb   = '1;
  assign m_axi_wvalid  = wvalid_q;
  assign m_axi_bready  = bready_q;
  assign m_axi_araddr  = araddr_q;
  assign m_axi_arprot  = 3'b000;
  assign m_axi_arvalid = arvalid_q;
  assign m_axi_rready  = rready_q;

endmodule
`default_nettype wire

// File: tb/tb_axil_cfg_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_axil_cfg_sequencer
// Description : Scoreboard bench for axil_cfg_sequencer with a reactive
//               AXI4-Lite slave model and a decoupled monitor.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_axil_cfg_sequencer;

  localparam int NUM_REGS = 4;
  localparam int ADDR_W   = 32;
  localparam int DATA_W   = 32;
  localparam int ERR_W    = $clog2(2*NUM_REGS+1);

  logic                       ACLK = 1'b0;
  logic                       ARESET;
  logic                       start;
  logic [NUM_REGS*DATA_W-1:0] cfg_data;
  logic                       busy, done, pass;
  logic [ERR_W-1:0]           err_cnt;
  logic [ADDR_W-1:0]          awaddr, araddr;
  logic [2:0]                 awprot, arprot;
  logic                       awvalid, awready, wvalid, wready, bvalid, bready;
  logic                       arvalid, arready, rvalid, rready;
  logic [DATA_W-1:0]          wdata, rdata;
  logic [DATA_W/8-1:0]        wstrb;
  logic [1:0]                 bresp, rresp;

  axil_cfg_sequencer #(
    .NUM_REGS (NUM_REGS),
    .ADDR_W   (ADDR_W),
    .DATA_W   (DATA_W),
    .BASE_ADDR(32'h0000_0000)
  ) dut (
    .ACLK(ACLK), .ARESET(ARESET), .start(start), .cfg_data(cfg_data),
    .busy(busy), .done(done), .pass(pass), .err_cnt(err_cnt),
    .m_axi_awaddr(awaddr), .m_axi_awprot(awprot), .m_axi_awvalid(awvalid),
    .m_axi_awready(awready), .m_axi_wdata(wdata), .m_axi_wstrb(wstrb),
    .m_axi_wvalid(wvalid), .m_axi_wready(wready), .m_axi_bresp(bresp),
    .m_axi_bvalid(bvalid), .m_axi_bready(bready), .m_axi_araddr(araddr),
    .m_axi_arprot(arprot), .m_axi_arvalid(arvalid), .m_axi_arready(arready),
    .m_axi_rdata(rdata), .m_axi_rresp(rresp), .m_axi_rvalid(rvalid),
    .m_axi_rready(rready)
  );

  always #5 ACLK = ~ACLK;

  int n_checks  = 0;
  int n_fail    = 0;
  int done_seen = 0;

  // Scoreboard queues
  logic [31:0] exp_aw [$];
  logic [31:0] exp_w  [$];
  logic [31:0] exp_ar [$];
  logic [4:0]  exp_res[$];   // {pass, err_cnt}

  // Slave behaviour knobs
  int          aw_delay = 0;
  int          w_delay  = 0;
  int          bad_rd_reg = -1;
  logic [31:0] bad_rd_val = 32'h0;
  int          bresp_err_reg = -1;
  int          rresp_err_reg = -1;
  logic [31:0] mem [0:15];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Reactive AXI4-Lite slave; drives on negedge, handshakes land on the next posedge.
  initial begin : slave
    int   aw_cnt, w_cnt;
    logic aw_got, w_got, b_pend, b_hs, r_pend, r_hs;
    logic [31:0] aw_a, w_d, b_a, r_a;
    aw_cnt = 0; w_cnt = 0;
    aw_got = 0; w_got = 0; b_pend = 0; b_hs = 0; r_pend = 0; r_hs = 0;
    aw_a = 0; w_d = 0; b_a = 0; r_a = 0;
    awready = 0; wready = 0; bvalid = 0; bresp = 0;
    arready = 0; rvalid = 0; rdata = 0; rresp = 0;
    for (int i = 0; i < 16; i++) mem[i] = 32'h0;
    forever begin
      @(negedge ACLK);
      if (ARESET) begin
        aw_cnt = 0; w_cnt = 0;
        aw_got = 0; w_got = 0; b_pend = 0; b_hs = 0; r_pend = 0; r_hs = 0;
        awready = 0; wready = 0; bvalid = 0; bresp = 0;
        arready = 0; rvalid = 0; rdata = 0; rresp = 0;
      end else begin
        if (b_hs) begin bvalid = 0; b_hs = 0; end
        if (r_hs) begin rvalid = 0; r_hs = 0; end
        if (b_pend) begin
          bvalid = 1;
          bresp  = (int'(b_a[5:2]) == bresp_err_reg) ? 2'b10 : 2'b00;
          b_pend = 0;
        end
        if (r_pend) begin
          rvalid = 1;
          rdata  = (int'(r_a[5:2]) == bad_rd_reg) ? bad_rd_val : mem[r_a[5:2]];
          rresp  = (int'(r_a[5:2]) == rresp_err_reg) ? 2'b10 : 2'b00;
          r_pend = 0;
        end
        awready = awvalid && !aw_got && (aw_cnt >= aw_delay);
        if (awvalid && !awready) aw_cnt++;
        wready  = wvalid && !w_got && (w_cnt >= w_delay);
        if (wvalid && !wready) w_cnt++;
        arready = arvalid;
        if (awvalid && awready) begin aw_got = 1; aw_a = awaddr; aw_cnt = 0; end
        if (wvalid && wready)   begin w_got = 1;  w_d = wdata;   w_cnt = 0;  end
        if (aw_got && w_got) begin
          mem[aw_a[5:2]] = w_d;
          b_a = aw_a; b_pend = 1; aw_got = 0; w_got = 0;
        end
        if (bvalid && bready)   b_hs = 1;
        if (arvalid && arready) begin r_pend = 1; r_a = araddr; end
        if (rvalid && rready)   r_hs = 1;
      end
    end
  end

  // Monitor: pops expectations whenever the DUT presents a handshake or done.
  initial begin : monitor
    logic p_aw, p_w, p_ar, h_aw, h_w, h_ar;
    logic [31:0] p_awaddr, p_wdata, p_araddr;
    logic [4:0] e;
    p_aw = 0; p_w = 0; p_ar = 0; h_aw = 0; h_w = 0; h_ar = 0;
    p_awaddr = 0; p_wdata = 0; p_araddr = 0;
    forever begin
      @(negedge ACLK);
      #1;
      if (ARESET) begin
        p_aw = 0; p_w = 0; p_ar = 0; h_aw = 0; h_w = 0; h_ar = 0;
      end else begin
        if (p_aw) begin check("aw_hold_valid", awvalid, 1); check("aw_hold_addr", awaddr, p_awaddr); end
        if (p_w)  begin check("w_hold_valid", wvalid, 1);   check("w_hold_data", wdata, p_wdata); end
        if (p_ar) begin check("ar_hold_valid", arvalid, 1); check("ar_hold_addr", araddr, p_araddr); end
        if (h_aw) check("aw_drop_after_hs", awvalid, 0);
        if (h_w)  check("w_drop_after_hs", wvalid, 0);
        if (h_ar) check("ar_drop_after_hs", arvalid, 0);
        if (awvalid && awready) begin
          if (exp_aw.size() == 0) begin
            n_checks++; n_fail++;
            $display("FAIL aw_unexpected: got addr 0x%0h expected no write", awaddr);
          end else check("aw_addr", awaddr, exp_aw.pop_front());
        end
        if (wvalid && wready) begin
          if (exp_w.size() == 0) begin
            n_checks++; n_fail++;
            $display("FAIL w_unexpected: got data 0x%0h expected no write", wdata);
          end else check("w_data", wdata, exp_w.pop_front());
        end
        if (arvalid && arready) begin
          if (exp_ar.size() == 0) begin
            n_checks++; n_fail++;
            $display("FAIL ar_unexpected: got addr 0x%0h expected no read", araddr);
          end else check("ar_addr", araddr, exp_ar.pop_front());
        end
        if (done) begin
          done_seen++;
          if (exp_res.size() == 0) begin
            n_checks++; n_fail++;
            $display("FAIL done_unexpected: got done=1 expected no sequence end");
          end else begin
            e = exp_res.pop_front();
            check("done_pass", pass, e[4]);
            check("done_err_cnt", err_cnt, e[3:0]);
            check("done_busy_low", busy, 0);
          end
        end
        p_aw = awvalid && !awready; p_awaddr = awaddr;
        p_w  = wvalid  && !wready;  p_wdata  = wdata;
        p_ar = arvalid && !arready; p_araddr = araddr;
        h_aw = awvalid && awready;
        h_w  = wvalid  && wready;
        h_ar = arvalid && arready;
      end
    end
  end

  task automatic push_exp(input logic [127:0] cfg, input logic ep, input logic [3:0] ee);
    for (int i = 0; i < NUM_REGS; i++) begin
      exp_aw.push_back(32'(i*4));
      exp_w.push_back(cfg[i*32 +: 32]);
    end
    for (int i = 0; i < NUM_REGS; i++) exp_ar.push_back(32'(i*4));
    exp_res.push_back({ep, ee});
  endtask

  task automatic pulse_start(input logic [127:0] cfg);
    cfg_data = cfg;
    start    = 1;
    @(negedge ACLK);
    start    = 0;
    cfg_data = {4{32'hFFFF_FFFF}};
    check("busy_after_start", busy, 1);
  endtask

  task automatic wait_done(input int target);
    int budget;
    budget = 1000;
    while (done_seen < target && budget > 0) begin
      @(negedge ACLK);
      budget--;
    end
    n_checks++;
    if (done_seen < target) begin
      n_fail++;
      $display("FAIL done_timeout: got %0d done pulses expected %0d", done_seen, target);
    end
  endtask

  task automatic end_check(input logic ep, input logic [3:0] ee);
    repeat (3) @(negedge ACLK);
    check("pass_held", pass, ep);
    check("err_cnt_held", err_cnt, ee);
    check("busy_idle", busy, 0);
    check("sb_empty", exp_aw.size() + exp_w.size() + exp_ar.size() + exp_res.size(), 0);
  endtask

  task automatic default_slave();
    aw_delay = 0; w_delay = 0; bad_rd_reg = -1; bad_rd_val = 0;
    bresp_err_reg = -1; rresp_err_reg = -1;
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stimulus
    logic [127:0] cfg;
    int base, budget;
    ARESET = 1; start = 0; cfg_data = '0;
    repeat (3) @(negedge ACLK);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_pass", pass, 0);
    check("rst_err_cnt", err_cnt, 0);
    check("rst_awvalid", awvalid, 0);
    check("rst_wvalid", wvalid, 0);
    check("rst_arvalid", arvalid, 0);
    check("rst_bready", bready, 0);
    check("rst_rready", rready, 0);
    check("rst_awaddr", awaddr, 0);
    check("rst_wdata", wdata, 0);
    check("wstrb_ones", wstrb, 4'hF);
    check("prot_zero", {awprot, arprot}, 6'b0);
    ARESET = 0;
    @(negedge ACLK);

    // 1: zero-wait slave, words 1..4
    default_slave();
    cfg = {32'd4, 32'd3, 32'd2, 32'd1};
    push_exp(cfg, 1'b1, 4'd0);
    pulse_start(cfg);
    wait_done(1);
    end_check(1'b1, 4'd0);

    // 2a: AW delayed by 3 cycles, W immediate
    default_slave(); aw_delay = 3;
    cfg = {32'hDEAD_0003, 32'hCAFE_0002, 32'h1234_5678, 32'hA5A5_5A5A};
    push_exp(cfg, 1'b1, 4'd0);
    pulse_start(cfg);
    wait_done(2);
    end_check(1'b1, 4'd0);

    // 2b: W delayed by 3 cycles, AW immediate
    default_slave(); w_delay = 3;
    cfg = {32'h0000_00FF, 32'hFFFF_0000, 32'h8000_0001, 32'h7FFF_FFFE};
    push_exp(cfg, 1'b1, 4'd0);
    pulse_start(cfg);
    wait_done(3);
    end_check(1'b1, 4'd0);

    // 3: wrong read data on register 2
    default_slave(); bad_rd_reg = 2; bad_rd_val = 32'h5;
    cfg = {32'h40, 32'h30, 32'h20, 32'h10};
    push_exp(cfg, 1'b0, 4'd1);
    pulse_start(cfg);
    wait_done(4);
    end_check(1'b0, 4'd1);

    // 4: SLVERR on write 0 and read 3
    default_slave(); bresp_err_reg = 0; rresp_err_reg = 3;
    cfg = {32'h0BAD_0004, 32'h0BAD_0003, 32'h0BAD_0002, 32'h0BAD_0001};
    push_exp(cfg, 1'b0, 4'd2);
    pulse_start(cfg);
    wait_done(5);
    end_check(1'b0, 4'd2);

    // 5: start held 20 cycles then re-pulsed while busy -> one sequence
    default_slave(); aw_delay = 3;
    cfg = {32'h5555_0004, 32'h5555_0003, 32'h5555_0002, 32'h5555_0001};
    push_exp(cfg, 1'b1, 4'd0);
    base = done_seen;
    cfg_data = cfg;
    start = 1;
    @(negedge ACLK);
    check("busy_held_start", busy, 1);
    repeat (19) @(negedge ACLK);
    start = 0;
    repeat (2) @(negedge ACLK);
    check("busy_before_repulse", busy, 1);
    start = 1;
    @(negedge ACLK);
    start = 0;
    wait_done(base + 1);
    repeat (40) @(negedge ACLK);
    check("single_done", done_seen, base + 1);
    end_check(1'b1, 4'd0);

    // 6: reset during RD_RESP of register 1, then a clean sequence
    default_slave(); bad_rd_reg = 0; bad_rd_val = 32'hFFFF_FFFF;
    cfg = {32'h6666_0004, 32'h6666_0003, 32'h6666_0002, 32'h6666_0001};
    push_exp(cfg, 1'b0, 4'd1);
    pulse_start(cfg);
    budget = 200;
    while (!(rready && araddr == 32'h4) && budget > 0) begin
      @(negedge ACLK);
      budget--;
    end
    check("reached_rd_resp", {31'b0, rready}, 1);
    check("pre_reset_err_cnt", err_cnt, 1);
    ARESET = 1;
    exp_aw.delete(); exp_w.delete(); exp_ar.delete(); exp_res.delete();
    @(negedge ACLK);
    check("mid_rst_awvalid", awvalid, 0);
    check("mid_rst_wvalid", wvalid, 0);
    check("mid_rst_arvalid", arvalid, 0);
    check("mid_rst_rready", rready, 0);
    check("mid_rst_bready", bready, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_err_cnt", err_cnt, 0);
    @(negedge ACLK);
    ARESET = 0;
    default_slave();
    @(negedge ACLK);
    base = done_seen;
    cfg = {32'h7777_0004, 32'h7777_0003, 32'h7777_0002, 32'h7777_0001};
    push_exp(cfg, 1'b1, 4'd0);
    pulse_start(cfg);
    wait_done(base + 1);
    end_check(1'b1, 4'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
